// File: rtl/alloc_rsp_arbiter_pkg.sv
// Shared widths, fail-reason codes and source encodings for the alloc response path.
// Pure declarations; no latency or backpressure of its own.
package alloc_rsp_arbiter_pkg;

    localparam int REQ_ID_WIDTH       = 8;
    localparam int ALL_PAGE_IDX_WIDTH = 14;
    localparam int FAIL_REASON_WIDTH  = 2;

    localparam logic [FAIL_REASON_WIDTH-1:0] ALLOC_FAIL_REASON_NONE    = 2'd0;
    localparam logic [FAIL_REASON_WIDTH-1:0] ALLOC_FAIL_REASON_NO_PAGE = 2'd1;
    localparam logic [FAIL_REASON_WIDTH-1:0] ALLOC_FAIL_REASON_QUOTA   = 2'd2;
    localparam logic [FAIL_REASON_WIDTH-1:0] ALLOC_FAIL_REASON_INVALID = 2'd3;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/alloc_rsp_arbiter_if.sv
// Producer-side and FIFO-side signals of the alloc response arbiter.
// slave = arbiter view, master = the surrounding logic driving it.
interface alloc_rsp_arbiter_if
    import alloc_rsp_arbiter_pkg::*;
#(
    parameter int ID_WIDTH       = REQ_ID_WIDTH,
    parameter int PAGE_IDX_WIDTH = ALL_PAGE_IDX_WIDTH,
    parameter int REASON_WIDTH   = FAIL_REASON_WIDTH
);
    logic                      a_valid;
    logic [ID_WIDTH-1:0]       a_id;
    logic [REASON_WIDTH-1:0]   a_fail_reason;
    logic                      a_almost_full;

    logic                      b_valid;
    logic [ID_WIDTH-1:0]       b_id;
    logic [PAGE_IDX_WIDTH-1:0] b_page_idx;
    logic                      b_almost_full;

    logic                      rsp_write_en;
    logic [ID_WIDTH-1:0]       rsp_id;
    logic [PAGE_IDX_WIDTH-1:0] rsp_page_idx;
    logic                      rsp_fail;
    logic [REASON_WIDTH-1:0]   rsp_fail_reason;
    logic                      rsp_fifo_full;
    logic                      rsp_fifo_almost_full;

    logic                      overflow;
    logic [7:0]                drop_count;

    modport slave (
        input  a_valid, a_id, a_fail_reason,
        output a_almost_full,
        input  b_valid, b_id, b_page_idx,
        output b_almost_full,
        output rsp_write_en, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason,
        input  rsp_fifo_full, rsp_fifo_almost_full,
        output overflow, drop_count
    );

    modport master (
        output a_valid, a_id, a_fail_reason,
        input  a_almost_full,
        output b_valid, b_id, b_page_idx,
        input  b_almost_full,
        input  rsp_write_en, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason,
        output rsp_fifo_full, rsp_fifo_almost_full,
        input  overflow, drop_count
    );

endinterface

// File: rtl/alloc_rsp_arbiter_rsp_skid_buf.sv
// Small synchronous FIFO holding one producer's responses; dout is the head, valid one cycle after push.
// A push while full is taken only if a pop happens in the same cycle; otherwise it is ignored here.
module rsp_skid_buf #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alloc_rsp_arbiter.sv
// Round-robin merge of dispatcher fail and FDT success responses into the alloc response FIFO.
// Latency 2 cycles push-to-write; FIFO backpressure stalls grants, producers see per-source almost_full, overflow drops are counted.
module alloc_rsp_arbiter
    import alloc_rsp_arbiter_pkg::*;
#(
    parameter int ID_WIDTH       = REQ_ID_WIDTH,
    parameter int PAGE_IDX_WIDTH = ALL_PAGE_IDX_WIDTH,
    parameter int REASON_WIDTH   = FAIL_REASON_WIDTH,
    parameter int BUF_DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst,
    alloc_rsp_arbiter_if.slave  io
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]     id;
        logic [REASON_WIDTH-1:0] reason;
    } a_ent_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]       id;
        logic [PAGE_IDX_WIDTH-1:0] page_idx;
    } b_ent_t;

    a_ent_t              a_din;
    a_ent_t              a_dout;
    logic                a_empty;
    logic                a_full;
    logic [CNT_W-1:0]    a_count;

    b_ent_t              b_din;
    b_ent_t              b_dout;
    logic                b_empty;
    logic                b_full;
    logic [CNT_W-1:0]    b_count;

    logic                can_write;
    logic                a_gnt;
    logic                b_gnt;
    logic                a_drop;
    logic                b_drop;
    logic [1:0]          drop_inc;

    src_t                      rr_last;
    logic                      rsp_vld_q;
    logic [ID_WIDTH-1:0]       rsp_id_q;
    logic [PAGE_IDX_WIDTH-1:0] rsp_page_idx_q;
    logic                      rsp_fail_q;
    logic [REASON_WIDTH-1:0]   rsp_reason_q;
    logic                      overflow_q;
    logic [7:0]                drop_cnt_q;

    assign a_din.id       = io.a_id;
    assign a_din.reason   = io.a_fail_reason;
    assign b_din.id       = io.b_id;
    assign b_din.page_idx = io.b_page_idx;

    rsp_skid_buf #(
        .WIDTH ($bits(a_ent_t)),
        .DEPTH (BUF_DEPTH)
    ) u_a_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (io.a_valid),
        .pop   (a_gnt),
        .din   (a_din),
        .dout  (a_dout),
        .empty (a_empty),
        .full  (a_full),
        .count (a_count)
    );

    rsp_skid_buf #(
        .WIDTH ($bits(b_ent_t)),
        .DEPTH (BUF_DEPTH)
    ) u_b_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (io.b_valid),
        .pop   (b_gnt),
        .din   (b_din),
        .dout  (b_dout),
        .empty (b_empty),
        .full  (b_full),
        .count (b_count)
    );

    // The registered write still in flight consumes the FIFO's last free slot.
    always_comb begin
        can_write = !io.rsp_fifo_full && !(rsp_vld_q && io.rsp_fifo_almost_full);
        a_gnt     = can_write && !a_empty && (b_empty || rr_last == SRC_B);
        b_gnt     = can_write && !b_empty && !a_gnt;
        a_drop    = io.a_valid && a_full && !a_gnt;
        b_drop    = io.b_valid && b_full && !b_gnt;
        drop_inc  = {1'b0, a_drop} + {1'b0, b_drop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last        <= SRC_B;
            rsp_vld_q      <= 1'b0;
            rsp_id_q       <= '0;
            rsp_page_idx_q <= '0;
            rsp_fail_q     <= 1'b0;
            rsp_reason_q   <= '0;
            overflow_q     <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            rsp_vld_q <= a_gnt || b_gnt;
            if (a_gnt) begin
                rr_last        <= SRC_A;
                rsp_id_q       <= a_dout.id;
                rsp_page_idx_q <= '0;
                rsp_fail_q     <= 1'b1;
                rsp_reason_q   <= a_dout.reason;
            end else if (b_gnt) begin
                rr_last        <= SRC_B;
                rsp_id_q       <= b_dout.id;
                rsp_page_idx_q <= b_dout.page_idx;
                rsp_fail_q     <= 1'b0;
                rsp_reason_q   <= '0;
            end
            if (a_drop || b_drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= sat_add8(drop_cnt_q, drop_inc);
            end
        end
    end

    assign io.rsp_write_en    = rsp_vld_q;
    assign io.rsp_id          = rsp_id_q;
    assign io.rsp_page_idx    = rsp_page_idx_q;
    assign io.rsp_fail        = rsp_fail_q;
    assign io.rsp_fail_reason = rsp_reason_q;
    assign io.overflow        = overflow_q;
    assign io.drop_count      = drop_cnt_q;

    assign io.a_almost_full = io.rsp_fifo_almost_full || (a_count >= CNT_W'(BUF_DEPTH - 1));
    assign io.b_almost_full = io.rsp_fifo_almost_full || (b_count >= CNT_W'(BUF_DEPTH - 1));

endmodule

// File: tb/tb_alloc_rsp_arbiter.sv
// Scoreboard bench for alloc_rsp_arbiter: directed pushes queue hand-ordered expected writes,
// a negedge monitor pops and compares every rsp_write_en beat.
module tb_alloc_rsp_arbiter;
    import alloc_rsp_arbiter_pkg::*;

    typedef logic [24:0] ent_t;   // {id[7:0], page_idx[13:0], fail, reason[1:0]}

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    ent_t exp_q [$];

    always #5 clk = ~clk;

    alloc_rsp_arbiter_if #(.ID_WIDTH(8), .PAGE_IDX_WIDTH(14), .REASON_WIDTH(2)) io ();

    alloc_rsp_arbiter #(
        .ID_WIDTH       (8),
        .PAGE_IDX_WIDTH (14),
        .REASON_WIDTH   (2),
        .BUF_DEPTH      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    function automatic ent_t ent_a(input logic [7:0] id, input logic [1:0] reason);
        return {id, 14'h0, 1'b1, reason};
    endfunction

    function automatic ent_t ent_b(input logic [7:0] id, input logic [13:0] pg);
        return {id, pg, 1'b0, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [7:0] id, input logic [1:0] reason);
        io.a_valid       = 1'b1;
        io.a_id          = id;
        io.a_fail_reason = reason;
    endtask

    task automatic drive_b(input logic [7:0] id, input logic [13:0] pg);
        io.b_valid    = 1'b1;
        io.b_id       = id;
        io.b_page_idx = pg;
    endtask

    task automatic idle();
        io.a_valid = 1'b0;
        io.b_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected writes missing after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    always @(negedge clk) begin : monitor
        ent_t e;
        if (io.rsp_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got id 0x%0h page 0x%0h fail %0b, expected no write",
                         io.rsp_id, io.rsp_page_idx, io.rsp_fail);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_entry", {io.rsp_id, io.rsp_page_idx, io.rsp_fail, io.rsp_fail_reason}, e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        io.a_id                 = '0;
        io.a_fail_reason        = '0;
        io.b_id                 = '0;
        io.b_page_idx           = '0;
        io.rsp_fifo_full        = 1'b0;
        io.rsp_fifo_almost_full = 1'b0;

        // Reset state
        tick();
        chk("rst_write_en", io.rsp_write_en, 0);
        chk("rst_data", {io.rsp_id, io.rsp_page_idx, io.rsp_fail, io.rsp_fail_reason}, 0);
        chk("rst_overflow_drop", {io.overflow, io.drop_count}, 0);
        chk("rst_almost_full", {io.a_almost_full, io.b_almost_full}, 0);
        rst = 1'b0;
        tick();

        // Single A response: write exactly two cycles later, data held afterwards
        drive_a(8'h12, ALLOC_FAIL_REASON_NO_PAGE);
        exp_q.push_back(ent_a(8'h12, 2'd1));
        tick();
        idle();
        chk("t1_lat_n1", io.rsp_write_en, 0);
        tick();
        chk("t1_lat_n2", io.rsp_write_en, 1);
        tick();
        chk("t1_lat_n3", io.rsp_write_en, 0);
        chk("t1_hold_id", io.rsp_id, 8'h12);

        // FIFO almost full: throttles both producers and spaces writes by one idle cycle
        io.rsp_fifo_almost_full = 1'b1;
        #1;
        chk("t1b_af_follow", {io.a_almost_full, io.b_almost_full}, 2'b11);
        drive_a(8'h21, ALLOC_FAIL_REASON_QUOTA);
        exp_q.push_back(ent_a(8'h21, 2'd2));
        exp_q.push_back(ent_a(8'h22, 2'd3));
        tick();
        drive_a(8'h22, ALLOC_FAIL_REASON_INVALID);
        tick();
        idle();
        chk("t1b_we_c2", io.rsp_write_en, 1);
        tick();
        chk("t1b_we_c3_stall", io.rsp_write_en, 0);
        tick();
        chk("t1b_we_c4", io.rsp_write_en, 1);
        io.rsp_fifo_almost_full = 1'b0;
        wait_drain("t1b_drain", 10);

        // Simultaneous A and B after reset: A first, then B on the next cycle
        do_reset();
        drive_a(8'h03, 2'd2);
        drive_b(8'h07, 14'h155);
        exp_q.push_back(ent_a(8'h03, 2'd2));
        exp_q.push_back(ent_b(8'h07, 14'h155));
        tick();
        idle();
        chk("t2_we_n1", io.rsp_write_en, 0);
        tick();
        chk("t2_we_n2", io.rsp_write_en, 1);
        tick();
        chk("t2_we_n3", io.rsp_write_en, 1);
        tick();
        chk("t2_we_n4", io.rsp_write_en, 0);

        // Both pulse 8 cycles: strict alternation; B's 8th push meets a full buffer and is dropped
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(ent_a(8'h20 + 8'(i), 2'(i)));
            if (i < 7) exp_q.push_back(ent_b(8'h40 + 8'(i), 14'h100 + 14'(i)));
        end
        for (int i = 0; i < 8; i++) begin
            drive_a(8'h20 + 8'(i), 2'(i));
            drive_b(8'h40 + 8'(i), 14'h100 + 14'(i));
            tick();
        end
        idle();
        wait_drain("t3_drain", 30);
        chk("t3_overflow", io.overflow, 1);
        chk("t3_drop_count", io.drop_count, 1);

        // FIFO full: 4 B pushes fill the buffer, 5th is dropped
        do_reset();
        io.rsp_fifo_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_b(8'h50 + 8'(k), 14'h200 + 14'(k));
            tick();
            chk("t4_b_almost_full", io.b_almost_full, (k >= 2) ? 1 : 0);
        end
        drive_b(8'h54, 14'h204);
        tick();
        idle();
        chk("t4_overflow", io.overflow, 1);
        chk("t4_drop_count", io.drop_count, 1);
        chk("t4_a_almost_full", io.a_almost_full, 0);
        tick();
        tick();
        chk("t4_no_write", io.rsp_write_en, 0);

        // Release FIFO while pushing into the full buffer: push accepted via simultaneous pop
        for (int k = 0; k < 4; k++) exp_q.push_back(ent_b(8'h50 + 8'(k), 14'h200 + 14'(k)));
        exp_q.push_back(ent_b(8'h55, 14'h205));
        drive_b(8'h55, 14'h205);
        io.rsp_fifo_full = 1'b0;
        tick();
        idle();
        chk("t5_drop_unchanged", io.drop_count, 1);
        wait_drain("t5_drain", 15);
        chk("t5_overflow_sticky", io.overflow, 1);

        // Reset flushes buffered entries; arbitration restarts with A preferred
        do_reset();
        io.rsp_fifo_full = 1'b1;
        drive_a(8'h60, 2'd1);
        drive_b(8'h70, 14'h300);
        tick();
        drive_a(8'h61, 2'd1);
        drive_b(8'h71, 14'h301);
        tick();
        idle();
        chk("t6_af_two_entries", {io.a_almost_full, io.b_almost_full}, 2'b00);
        rst = 1'b1;
        io.rsp_fifo_full = 1'b0;
        tick();
        rst = 1'b0;
        chk("t6_we_after_rst", io.rsp_write_en, 0);
        chk("t6_drop_cleared", {io.overflow, io.drop_count}, 0);
        for (int k = 0; k < 5; k++) tick();
        drive_a(8'h62, 2'd3);
        drive_b(8'h72, 14'h3FF);
        exp_q.push_back(ent_a(8'h62, 2'd3));
        exp_q.push_back(ent_b(8'h72, 14'h3FF));
        tick();
        idle();
        wait_drain("t6_drain", 10);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
